// File: rtl/tcam_sched_pkg.sv
// tcam_sched_pkg
// Shared constants and types for the TCAM port scheduler.
//   NPORT    : number of CAM match/write ports shared by the scheduler
//   CLR_PATT : pattern written into every entry by the flush engine
//   CLR_MASK : mask written into every entry by the flush engine
//   state_t  : scheduler FSM state
package tcam_sched_pkg;

    localparam int NPORT = 3;

    // Cleared-entry encoding, sliced down to the CAM word width at use.
    // Wide enough for any CAM word up to 256 bits.
    localparam int               CLR_W    = 256;
    localparam logic [CLR_W-1:0] CLR_PATT = '0;
    localparam logic [CLR_W-1:0] CLR_MASK = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/tcam_rr_pick3.sv
// tcam_rr_pick3
// Combinational round-robin pick of up to three requesters.
//   req      : request vector, one bit per requester
//   rr_ptr   : requester index the scan starts from
//   grant    : one bit per granted requester
//   port_idx : requester index assigned to each CAM port, in grant order
//   port_vld : port carries a granted requester
//   next_ptr : one past the last granted requester (rr_ptr if none)
module tcam_rr_pick3
    import tcam_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]           req,
    input  logic [PW-1:0]             rr_ptr,
    output logic [NREQ-1:0]           grant,
    output logic [NPORT-1:0][PW-1:0]  port_idx,
    output logic [NPORT-1:0]          port_vld,
    output logic [PW-1:0]             next_ptr
);

    logic [PW-1:0] idx;
    logic [1:0]    n_gnt;

    always_comb begin
        grant    = '0;
        port_idx = '0;
        port_vld = '0;
        next_ptr = rr_ptr;
        idx      = '0;
        n_gnt    = '0;
        for (int i = 0; i < NREQ; i++) begin
            // modulo-NREQ walk without a divider
            if (int'(rr_ptr) + i >= NREQ)
                idx = PW'(int'(rr_ptr) + i - NREQ);
            else
                idx = PW'(int'(rr_ptr) + i);
            if (req[idx] && (n_gnt != 2'd3)) begin
                grant[idx]      = 1'b1;
                port_idx[n_gnt] = idx;
                port_vld[n_gnt] = 1'b1;
                n_gnt           = n_gnt + 2'd1;
                next_ptr        = (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
            end
        end
    end

endmodule

// File: rtl/tcam_port_sched.sv
// tcam_port_sched
// Shares the three match/write ports of a triple-port ternary CAM between
// NREQ lookup requesters, one update channel and a full-array flush engine.
//   lkp_valid/lkp_ready/lkp_key     : lookup requests, ready is combinational
//   rsp_valid/rsp_match/rsp_addr    : registered lookup results, one cycle later
//   upd_valid/upd_ready/upd_*       : single-entry writes on CAM write port 0
//   flush_req/flush_done/busy       : full-array clear, three entries per cycle
//   cam_w*                          : per-port CAM write controls
//   cam_mPatt/cam_match/cam_mAddr   : per-port CAM search key and result
//
// state | meaning
// IDLE  | lookups and updates are served
// FLUSH | flush engine owns all write ports, clients are stalled
module tcam_port_sched
    import tcam_sched_pkg::*;
#(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 36,
    parameter  int NREQ  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             lkp_valid,
    output logic [NREQ-1:0]             lkp_ready,
    input  logic [NREQ-1:0][WIDTH-1:0]  lkp_key,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [NREQ-1:0]             rsp_match,
    output logic [NREQ-1:0][AW-1:0]     rsp_addr,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [AW-1:0]               upd_addr,
    input  logic [WIDTH-1:0]            upd_patt,
    input  logic [WIDTH-1:0]            upd_mask,
    input  logic                        flush_req,
    output logic                        flush_done,
    output logic                        busy,
    output logic [NPORT-1:0]            cam_wEn,
    output logic [NPORT-1:0][AW-1:0]    cam_wAddr,
    output logic [NPORT-1:0][WIDTH-1:0] cam_wPatt,
    output logic [NPORT-1:0][WIDTH-1:0] cam_wMask,
    output logic [NPORT-1:0][WIDTH-1:0] cam_mPatt,
    input  logic [NPORT-1:0]            cam_match,
    input  logic [NPORT-1:0][AW-1:0]    cam_mAddr
);

    // two spare bits so cnt+2 and cnt+3 never wrap
    localparam int CW = AW + 2;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          faddr;
    logic                   flush_last;
    logic                   idle_en;
    logic [PW-1:0]          rr_ptr, next_ptr;
    logic [NREQ-1:0]        grant;
    logic [NPORT-1:0][PW-1:0] port_idx;
    logic [NPORT-1:0]       port_vld;
    logic [NREQ-1:0]        rsp_valid_d, rsp_match_d;
    logic [NREQ-1:0][AW-1:0] rsp_addr_d;

    tcam_rr_pick3 #(.NREQ(NREQ)) u_pick (
        .req      (lkp_valid),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .port_idx (port_idx),
        .port_vld (port_vld),
        .next_ptr (next_ptr)
    );

    assign flush_last = (cnt + CW'(NPORT)) >= CW'(DEPTH);
    // grants are suppressed combinationally while reset is asserted
    assign idle_en    = rst_n && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rr_ptr     <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_done <= (state == FLUSH) && flush_last;
            cnt        <= (state == FLUSH) ? cnt + CW'(NPORT) : '0;
            if ((state == IDLE) && (|port_vld))
                rr_ptr <= next_ptr;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (flush_req)  state_nxt = FLUSH;
            FLUSH:   if (flush_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == FLUSH);
        lkp_ready = idle_en ? grant : '0;
        upd_ready = idle_en && !flush_req;
        cam_wEn   = '0;
        cam_wAddr = '0;
        cam_wPatt = '0;
        cam_wMask = '0;
        cam_mPatt = '0;
        faddr     = '0;
        if (state == FLUSH) begin
            for (int k = 0; k < NPORT; k++) begin
                faddr = cnt + CW'(k);
                if (faddr < CW'(DEPTH)) begin
                    cam_wEn[k]   = 1'b1;
                    cam_wAddr[k] = faddr[AW-1:0];
                    cam_wPatt[k] = CLR_PATT[WIDTH-1:0];
                    cam_wMask[k] = CLR_MASK[WIDTH-1:0];
                end
            end
        end else if (upd_valid && upd_ready) begin
            cam_wEn[0]   = 1'b1;
            cam_wAddr[0] = upd_addr;
            cam_wPatt[0] = upd_patt;
            cam_wMask[0] = upd_mask;
        end
        if (idle_en) begin
            for (int k = 0; k < NPORT; k++) begin
                if (port_vld[k])
                    cam_mPatt[k] = lkp_key[port_idx[k]];
            end
        end
    end

    // route each port's result back to the requester that owned the port
    always_comb begin
        rsp_valid_d = '0;
        rsp_match_d = '0;
        rsp_addr_d  = '0;
        if (idle_en) begin
            for (int k = 0; k < NPORT; k++) begin
                if (port_vld[k]) begin
                    rsp_valid_d[port_idx[k]] = 1'b1;
                    rsp_match_d[port_idx[k]] = cam_match[k];
                    rsp_addr_d[port_idx[k]]  = cam_mAddr[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_match <= '0;
            rsp_addr  <= '0;
        end else begin
            rsp_valid <= rsp_valid_d;
            rsp_match <= rsp_match_d;
            rsp_addr  <= rsp_addr_d;
        end
    end

endmodule

// File: tb/tb_tcam_port_sched.sv
// tb_tcam_port_sched
// Directed bench for tcam_port_sched with a small behavioural TCAM attached
// to the CAM ports (mask bit 1 = compare, lowest matching address wins).
module tb_tcam_port_sched;

    localparam int DEPTH = 64;
    localparam int WIDTH = 36;
    localparam int NREQ  = 4;
    localparam int AW    = 6;
    localparam logic [WIDTH-1:0] ONES = '1;

    logic                        clk;
    logic                        rst_n;
    logic [NREQ-1:0]             lkp_valid;
    logic [NREQ-1:0]             lkp_ready;
    logic [NREQ-1:0][WIDTH-1:0]  lkp_key;
    logic [NREQ-1:0]             rsp_valid;
    logic [NREQ-1:0]             rsp_match;
    logic [NREQ-1:0][AW-1:0]     rsp_addr;
    logic                        upd_valid;
    logic                        upd_ready;
    logic [AW-1:0]               upd_addr;
    logic [WIDTH-1:0]            upd_patt;
    logic [WIDTH-1:0]            upd_mask;
    logic                        flush_req;
    logic                        flush_done;
    logic                        busy;
    logic [2:0]                  cam_wEn;
    logic [2:0][AW-1:0]          cam_wAddr;
    logic [2:0][WIDTH-1:0]       cam_wPatt;
    logic [2:0][WIDTH-1:0]       cam_wMask;
    logic [2:0][WIDTH-1:0]       cam_mPatt;
    logic [2:0]                  cam_match;
    logic [2:0][AW-1:0]          cam_mAddr;

    tcam_port_sched #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lkp_valid  (lkp_valid),
        .lkp_ready  (lkp_ready),
        .lkp_key    (lkp_key),
        .rsp_valid  (rsp_valid),
        .rsp_match  (rsp_match),
        .rsp_addr   (rsp_addr),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_addr   (upd_addr),
        .upd_patt   (upd_patt),
        .upd_mask   (upd_mask),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .busy       (busy),
        .cam_wEn    (cam_wEn),
        .cam_wAddr  (cam_wAddr),
        .cam_wPatt  (cam_wPatt),
        .cam_wMask  (cam_wMask),
        .cam_mPatt  (cam_mPatt),
        .cam_match  (cam_match),
        .cam_mAddr  (cam_mAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural CAM
    logic [WIDTH-1:0] m_patt [DEPTH];
    logic [WIDTH-1:0] m_mask [DEPTH];
    logic             m_vld  [DEPTH];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (cam_wEn[k]) begin
                m_patt[cam_wAddr[k]] <= cam_wPatt[k];
                m_mask[cam_wAddr[k]] <= cam_wMask[k];
                m_vld[cam_wAddr[k]]  <= 1'b1;
            end
        end
    end

    always_comb begin
        cam_match = '0;
        cam_mAddr = '0;
        for (int k = 0; k < 3; k++) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (m_vld[i] && (((cam_mPatt[k] ^ m_patt[i]) & m_mask[i]) == '0)) begin
                    cam_match[k] = 1'b1;
                    cam_mAddr[k] = AW'(i);
                end
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int busy_cnt, done_cnt, done_chk;
    logic [2:0]    last_wen;
    logic [AW-1:0] last_a0;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i]  = 1'b0;
            m_patt[i] = '0;
            m_mask[i] = '0;
        end
        rst_n     = 1'b0;
        lkp_valid = 4'b1111;
        for (int r = 0; r < NREQ; r++) lkp_key[r] = WIDTH'(36'h100 + r);
        upd_valid = 1'b1;
        upd_addr  = 6'd7;
        upd_patt  = 36'h12;
        upd_mask  = ONES;
        flush_req = 1'b0;

        // reset: everything quiet even with requests pending
        neg();
        chk("rst_lkp_ready", 64'(lkp_ready), 64'd0);
        chk("rst_upd_ready", 64'(upd_ready), 64'd0);
        chk("rst_wen", 64'(cam_wEn), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        lkp_valid = '0;
        upd_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // round robin with all four requesting
        lkp_valid = 4'b1111;
        neg();
        chk("rr0_ready", 64'(lkp_ready), 64'b0111);
        chk("rr0_mpatt0", 64'(cam_mPatt[0]), 64'h100);
        chk("rr0_mpatt1", 64'(cam_mPatt[1]), 64'h101);
        chk("rr0_mpatt2", 64'(cam_mPatt[2]), 64'h102);
        tick();
        chk("rr0_rsp_valid", 64'(rsp_valid), 64'b0111);
        neg();
        chk("rr1_ready", 64'(lkp_ready), 64'b1011);
        chk("rr1_mpatt0", 64'(cam_mPatt[0]), 64'h103);
        chk("rr1_mpatt1", 64'(cam_mPatt[1]), 64'h100);
        chk("rr1_mpatt2", 64'(cam_mPatt[2]), 64'h101);
        tick();
        chk("rr1_rsp_valid", 64'(rsp_valid), 64'b1011);
        lkp_valid = '0;

        // update with same-cycle and next-cycle lookups (rr_ptr=2)
        upd_valid  = 1'b1;
        upd_addr   = 6'd5;
        upd_patt   = 36'hAB;
        upd_mask   = ONES;
        lkp_valid  = 4'b0001;
        lkp_key[0] = 36'hAB;
        neg();
        chk("upd_ready", 64'(upd_ready), 64'd1);
        chk("upd_wen", 64'(cam_wEn), 64'b001);
        chk("upd_waddr", 64'(cam_wAddr[0]), 64'd5);
        chk("upd_wpatt", 64'(cam_wPatt[0]), 64'hAB);
        chk("upd_wmask", 64'(cam_wMask[0]), 64'(ONES));
        chk("upd_lkp_ready", 64'(lkp_ready), 64'b0001);
        tick();
        chk("upd_old_valid", 64'(rsp_valid), 64'b0001);
        chk("upd_old_miss", 64'(rsp_match), 64'd0);
        upd_valid = 1'b0;
        neg();
        chk("upd_wen_off", 64'(cam_wEn), 64'd0);
        tick();
        chk("upd_new_valid", 64'(rsp_valid), 64'b0001);
        chk("upd_new_hit", 64'(rsp_match), 64'b0001);
        chk("upd_new_addr", 64'(rsp_addr[0]), 64'd5);
        lkp_valid = '0;

        // single requester 2 (rr_ptr=1) for three cycles
        lkp_key[2] = 36'hAB;
        lkp_valid  = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            neg();
            chk("solo_ready", 64'(lkp_ready), 64'b0100);
            chk("solo_mpatt0", 64'(cam_mPatt[0]), 64'hAB);
            chk("solo_mpatt1", 64'(cam_mPatt[1]), 64'd0);
            tick();
            chk("solo_rsp_valid", 64'(rsp_valid), 64'b0100);
            chk("solo_rsp_match", 64'(rsp_match), 64'b0100);
            chk("solo_rsp_addr", 64'(rsp_addr[2]), 64'd5);
        end
        // rr_ptr must now be 3
        lkp_valid = 4'b1111;
        neg();
        chk("solo_ptr_probe", 64'(lkp_ready), 64'b1011);
        tick();
        chk("probe_rsp_valid", 64'(rsp_valid), 64'b1011);
        lkp_valid = '0;

        // flush_req together with an update and a lookup (rr_ptr=2)
        flush_req  = 1'b1;
        upd_valid  = 1'b1;
        upd_addr   = 6'd9;
        upd_patt   = 36'h77;
        lkp_valid  = 4'b0001;
        neg();
        chk("fl_upd_ready", 64'(upd_ready), 64'd0);
        chk("fl_req_wen", 64'(cam_wEn), 64'd0);
        chk("fl_req_busy", 64'(busy), 64'd0);
        chk("fl_req_lkp", 64'(lkp_ready), 64'b0001);
        tick();
        flush_req = 1'b0;
        lkp_valid = 4'b1111;
        chk("fl_pre_rsp_valid", 64'(rsp_valid), 64'b0001);
        chk("fl_pre_rsp_match", 64'(rsp_match), 64'b0001);
        neg();
        chk("fl0_busy", 64'(busy), 64'd1);
        chk("fl0_wen", 64'(cam_wEn), 64'b111);
        chk("fl0_waddr", 64'(cam_wAddr), {46'd0, 6'd2, 6'd1, 6'd0});
        chk("fl0_wpatt1", 64'(cam_wPatt[1]), 64'd0);
        chk("fl0_wmask2", 64'(cam_wMask[2]), 64'(ONES));
        chk("fl0_lkp_ready", 64'(lkp_ready), 64'd0);
        chk("fl0_upd_ready", 64'(upd_ready), 64'd0);
        busy_cnt = 1;
        done_cnt = 0;
        done_chk = 0;
        last_wen = cam_wEn;
        last_a0  = cam_wAddr[0];
        for (int c = 1; c < 30; c++) begin
            tick();
            flush_req = (c == 5);
            neg();
            if (busy) begin
                busy_cnt++;
                last_wen = cam_wEn;
                last_a0  = cam_wAddr[0];
            end
            if (flush_done) begin
                done_cnt++;
                if (done_chk == 0) begin
                    done_chk = 1;
                    chk("fl_done_busy", 64'(busy), 64'd0);
                    chk("fl_done_lkp_ready", 64'(lkp_ready), 64'b1110);
                end
            end
        end
        chk("fl_busy_cycles", 64'(busy_cnt), 64'd22);
        chk("fl_done_pulses", 64'(done_cnt), 64'd1);
        chk("fl_last_wen", 64'(last_wen), 64'b001);
        chk("fl_last_waddr", 64'(last_a0), 64'd63);
        tick();
        upd_valid = 1'b0;
        lkp_valid = 4'b0001;
        neg();
        chk("post_fl_lkp", 64'(lkp_ready), 64'b0001);
        tick();
        chk("post_fl_valid", 64'(rsp_valid), 64'b0001);
        chk("post_fl_miss", 64'(rsp_match), 64'd0);
        lkp_valid = '0;

        // reset in the middle of a flush
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (10) tick();
        chk("rstf_busy_before", 64'(busy), 64'd1);
        rst_n     = 1'b0;
        lkp_valid = 4'b1111;
        #1;
        chk("rstf_wen", 64'(cam_wEn), 64'd0);
        chk("rstf_busy", 64'(busy), 64'd0);
        chk("rstf_lkp_ready", 64'(lkp_ready), 64'd0);
        done_cnt = 0;
        repeat (3) begin
            neg();
            if (flush_done) done_cnt++;
        end
        tick();
        rst_n = 1'b1;
        neg();
        chk("rstf_rel_lkp", 64'(lkp_ready), 64'b0111);
        chk("rstf_rel_busy", 64'(busy), 64'd0);
        repeat (25) begin
            tick();
            neg();
            if (flush_done) done_cnt++;
        end
        chk("rstf_no_done", 64'(done_cnt), 64'd0);
        lkp_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
